// File: rtl/bcd_mmss_timer_if.sv
// Bundles the mm:ss timer's control inputs and its display/status outputs.
// master drives load/run/values in; slave is the timer itself.
interface bcd_mmss_timer_if #(
  parameter int MIN_DIGITS = 2
);
  logic                    load;
  logic [4*MIN_DIGITS-1:0] load_min;
  logic [7:0]              load_sec;
  logic                    mode;
  logic                    run;
  logic [4*MIN_DIGITS-1:0] min_bcd;
  logic [7:0]              sec_bcd;
  logic                    running;
  logic                    done;
  logic                    expire;
  logic                    sec_tick;

  modport master (
    output load, load_min, load_sec, mode, run,
    input  min_bcd, sec_bcd, running, done, expire, sec_tick
  );

  modport slave (
    input  load, load_min, load_sec, mode, run,
    output min_bcd, sec_bcd, running, done, expire, sec_tick
  );
endinterface

// File: rtl/bcd_mmss_timer.sv
// BCD mm:ss up/down timer with prescaled one-second steps, pause that keeps
// the sub-second phase, clamped load, sticky done and one-cycle expire pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | value loaded (or reset), waiting for run
// ST_RUN   | prescaler advancing, one step per TICKS_PER_SEC cycles
// ST_PAUSE | run dropped; value and prescaler phase frozen
// ST_DONE  | terminal value reached; frozen until load or reset
module bcd_mmss_timer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int MIN_DIGITS    = 2
) (
  input  logic               clk,
  input  logic               resetn,
  bcd_mmss_timer_if.slave    bus
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [MW-1:0] MIN_ALL9 = {MIN_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mode_q, mode_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          expire_q, expire_d;
  logic          tick_q, tick_d;

  logic [MW-1:0] step_min;
  logic [7:0]    step_sec;

  // Limit a single BCD digit to max (covers the A..F codes).
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    clamp_digit = (d > max) ? max : d;
  endfunction

  function automatic logic [MW-1:0] clamp_min(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      r[4*i +: 4] = clamp_digit(m[4*i +: 4], 4'd9);
    end
    clamp_min = r;
  endfunction

  // Ripple borrow through the minute digits, least significant first.
  function automatic logic [MW-1:0] min_dec(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          borrow;
    r      = m;
    borrow = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (borrow) begin
        if (m[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = m[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    min_dec = r;
  endfunction

  // Ripple carry through the minute digits, least significant first.
  function automatic logic [MW-1:0] min_inc(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          carry;
    r     = m;
    carry = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (carry) begin
        if (m[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = m[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    min_inc = r;
  endfunction

  function automatic logic is_terminal(input logic [MW-1:0] m, input logic [7:0] s,
                                       input logic up);
    if (up) begin
      is_terminal = (m == MIN_ALL9) && (s == 8'h59);
    end else begin
      is_terminal = (m == '0) && (s == 8'h00);
    end
  endfunction

  // One-second step candidate in the latched direction; only applied on a prescaler wrap.
  always_comb begin
    step_min = min_q;
    step_sec = sec_q;
    if (mode_q) begin
      if (sec_q[3:0] != 4'd9) begin
        step_sec[3:0] = sec_q[3:0] + 4'd1;
      end else begin
        step_sec[3:0] = 4'd0;
        if (sec_q[7:4] != 4'd5) begin
          step_sec[7:4] = sec_q[7:4] + 4'd1;
        end else begin
          step_sec[7:4] = 4'd0;
          step_min      = min_inc(min_q);
        end
      end
    end else begin
      if (sec_q[3:0] != 4'd0) begin
        step_sec[3:0] = sec_q[3:0] - 4'd1;
      end else begin
        step_sec[3:0] = 4'd9;
        if (sec_q[7:4] != 4'd0) begin
          step_sec[7:4] = sec_q[7:4] - 4'd1;
        end else begin
          step_sec[7:4] = 4'd5;
          step_min      = min_dec(min_q);
        end
      end
    end
  end

  // Next-state, value, prescaler and output-pulse logic; load overrides everything.
  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    expire_d = 1'b0;
    tick_d   = 1'b0;

    if (bus.load) begin
      min_d   = clamp_min(bus.load_min);
      sec_d   = {clamp_digit(bus.load_sec[7:4], 4'd5), clamp_digit(bus.load_sec[3:0], 4'd9)};
      mode_d  = bus.mode;
      presc_d = '0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (bus.run) begin
            // Starting at the terminal value finishes immediately without a step.
            if (is_terminal(min_q, sec_q, mode_q)) begin
              state_d  = ST_DONE;
              expire_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!bus.run) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PS_LAST) begin
            presc_d = '0;
            min_d   = step_min;
            sec_d   = step_sec;
            tick_d  = 1'b1;
            if (is_terminal(step_min, step_sec, mode_q)) begin
              state_d  = ST_DONE;
              expire_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // All state and outputs registered; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      presc_q   <= '0;
      mode_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expire_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      running_q <= running_d;
      done_q    <= done_d;
      expire_q  <= expire_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.min_bcd  = min_q;
  assign bus.sec_bcd  = sec_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.expire   = expire_q;
  assign bus.sec_tick = tick_q;

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Directed bench for bcd_mmss_timer with TICKS_PER_SEC=4, MIN_DIGITS=2.
module tb_bcd_mmss_timer;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  bcd_mmss_timer_if #(.MIN_DIGITS(2)) bus ();

  bcd_mmss_timer #(.TICKS_PER_SEC(4), .MIN_DIGITS(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] mn, input logic [7:0] sc,
                         input logic rn, input logic dn, input logic ex, input logic tk);
    chk({tag, ".min"},      {24'h0, bus.min_bcd}, {24'h0, mn});
    chk({tag, ".sec"},      {24'h0, bus.sec_bcd}, {24'h0, sc});
    chk({tag, ".running"},  {31'h0, bus.running}, {31'h0, rn});
    chk({tag, ".done"},     {31'h0, bus.done},    {31'h0, dn});
    chk({tag, ".expire"},   {31'h0, bus.expire},  {31'h0, ex});
    chk({tag, ".sec_tick"}, {31'h0, bus.sec_tick}, {31'h0, tk});
  endtask

  task automatic do_load(input logic [7:0] mn, input logic [7:0] sc, input logic md,
                         input logic rn);
    bus.load     = 1'b1;
    bus.load_min = mn;
    bus.load_sec = sc;
    bus.mode     = md;
    bus.run      = rn;
    tick(1);
    bus.load     = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    resetn       = 1'b0;
    bus.load     = 1'b0;
    bus.load_min = 8'h00;
    bus.load_sec = 8'h00;
    bus.mode     = 1'b0;
    bus.run      = 1'b0;

    // Reset state
    tick(2);
    chk_all("reset", 8'h00, 8'h00, 0, 0, 0, 0);
    resetn = 1'b1;
    tick(1);
    chk_all("post_reset", 8'h00, 8'h00, 0, 0, 0, 0);

    // 01:00 down: first step four edges after RUN entry, borrow to 00:59
    do_load(8'h01, 8'h00, 1'b0, 1'b0);
    chk_all("load_0100", 8'h01, 8'h00, 0, 0, 0, 0);
    bus.run = 1'b1;
    tick(1);
    chk_all("run_entry", 8'h01, 8'h00, 1, 0, 0, 0);
    tick(3);
    chk_all("pre_step1", 8'h01, 8'h00, 1, 0, 0, 0);
    tick(1);
    chk_all("step_0059", 8'h00, 8'h59, 1, 0, 0, 1);
    tick(1);
    chk_all("tick_drop", 8'h00, 8'h59, 1, 0, 0, 0);
    tick(3);
    chk_all("step_0058", 8'h00, 8'h58, 1, 0, 0, 1);

    // 00:02 down with run held through load: load wins, then count to DONE
    do_load(8'h00, 8'h02, 1'b0, 1'b1);
    chk_all("load_0002", 8'h00, 8'h02, 0, 0, 0, 0);
    tick(1);
    chk_all("run_0002", 8'h00, 8'h02, 1, 0, 0, 0);
    tick(4);
    chk_all("step_0001", 8'h00, 8'h01, 1, 0, 0, 1);
    tick(4);
    chk_all("step_0000", 8'h00, 8'h00, 0, 1, 1, 1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk_all("done_hold", 8'h00, 8'h00, 0, 1, 0, 0);
    end

    // 99:58 up: one step to 99:59 is terminal, no wrap afterwards
    do_load(8'h99, 8'h58, 1'b1, 1'b0);
    chk_all("load_9958", 8'h99, 8'h58, 0, 0, 0, 0);
    bus.run = 1'b1;
    tick(1);
    chk_all("run_9958", 8'h99, 8'h58, 1, 0, 0, 0);
    tick(4);
    chk_all("step_9959", 8'h99, 8'h59, 0, 1, 1, 1);
    tick(10);
    chk_all("up_no_wrap", 8'h99, 8'h59, 0, 1, 0, 0);

    // Pause/resume keeps prescaler phase
    do_load(8'h00, 8'h10, 1'b0, 1'b0);
    bus.run = 1'b1;
    tick(1);
    tick(4);
    chk_all("step_0009", 8'h00, 8'h09, 1, 0, 0, 1);
    tick(2);
    chk_all("phase2", 8'h00, 8'h09, 1, 0, 0, 0);
    bus.run = 1'b0;
    tick(1);
    chk_all("pause", 8'h00, 8'h09, 0, 0, 0, 0);
    tick(49);
    chk_all("pause_hold", 8'h00, 8'h09, 0, 0, 0, 0);
    bus.run = 1'b1;
    tick(1);
    chk_all("resume", 8'h00, 8'h09, 1, 0, 0, 0);
    tick(1);
    chk_all("resume_p3", 8'h00, 8'h09, 1, 0, 0, 0);
    tick(1);
    chk_all("step_0008", 8'h00, 8'h08, 1, 0, 0, 1);

    // Load with clamping lands exactly where a step would have happened
    tick(3);
    chk_all("pre_load_p3", 8'h00, 8'h08, 1, 0, 0, 0);
    do_load(8'hA3, 8'h6B, 1'b0, 1'b1);
    chk_all("clamp_9359", 8'h93, 8'h59, 0, 0, 0, 0);
    tick(1);
    chk_all("run_9359", 8'h93, 8'h59, 1, 0, 0, 0);
    tick(4);
    chk_all("step_9358", 8'h93, 8'h58, 1, 0, 0, 1);
    bus.run = 1'b0;
    do_load(8'hAF, 8'h7C, 1'b0, 1'b0);
    chk_all("clamp_9959", 8'h99, 8'h59, 0, 0, 0, 0);

    // Asynchronous reset mid-RUN
    bus.run = 1'b1;
    tick(3);
    chk_all("run_before_rst", 8'h99, 8'h59, 1, 0, 0, 0);
    #2;
    resetn = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 8'h00, 0, 0, 0, 0);
    bus.run = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(1);
    chk_all("rst_release", 8'h00, 8'h00, 0, 0, 0, 0);

    // Zero start: DONE on first RUN edge with no step
    do_load(8'h00, 8'h00, 1'b0, 1'b0);
    bus.run = 1'b1;
    tick(1);
    chk_all("zero_start", 8'h00, 8'h00, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk_all("zero_hold", 8'h00, 8'h00, 0, 1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_mmss_timer.md
Name: bcd_mmss_timer

Overview:
- Parametrised mm:ss timer that counts in BCD, one step per prescaled second.
- Successor to the single-digit-minute countdown used on the board. Adds:
  - parametrised minute digit count and tick divisor
  - count-up mode
  - pause/resume without losing sub-second phase
  - explicit load
  - sticky done flag plus a one-cycle expire pulse
- Outputs feed the hex_decoder display chain and game/alarm control logic.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per counted second; must be >= 2.
- MIN_DIGITS, 2, number of BCD minute digits (1..3); minute max is 10^MIN_DIGITS - 1.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- load  input  1  pulse; latches load_min, load_sec, mode
- load_min  input  4*MIN_DIGITS  BCD minutes, most significant digit in MSBs
- load_sec  input  8  BCD seconds, [7:4] tens, [3:0] ones
- mode  input  1  0 = count down, 1 = count up; sampled only on load
- run  input  1  level; 1 = count, 0 = pause
- min_bcd  output  4*MIN_DIGITS  current minutes
- sec_bcd  output  8  current seconds
- running  output  1  high in RUN
- done  output  1  sticky, high in DONE
- expire  output  1  one-cycle pulse on entry to DONE
- sec_tick  output  1  one-cycle pulse on each applied count step

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; min_bcd=0, sec_bcd=0, prescaler=0, latched mode=0.
  - running, done, expire, sec_tick all 0.
- All outputs are registered.
- States: IDLE, RUN, PAUSE, DONE.
- load has top priority, in any state:
  - min/sec take the clamped load values; mode is latched.
  - prescaler=0, done=0, next state IDLE.
  - run is ignored in the load cycle.
- Clamping on load:
  - any minute digit >9 -> 9; sec ones >9 -> 9; sec tens >5 -> 5.
  - Example: 0xAF minutes (MIN_DIGITS=2) -> 99; 0x7C seconds -> 59.
- IDLE or PAUSE with run=1 -> RUN.
- RUN with run=0 -> PAUSE; prescaler holds its value. PAUSE with run=0 holds everything.
- Prescaler in RUN:
  - increments each cycle.
  - when it equals TICKS_PER_SEC-1, it wraps to 0 and a step is applied on that same edge, with sec_tick=1 for that cycle.
  - First step therefore lands TICKS_PER_SEC cycles after entering RUN from a fresh load.
- Down step:
  - sec ones decrement; borrow 0->9 into sec tens.
  - tens borrow 0->5 into minutes.
  - minutes decrement digit-wise with 0->9 borrow.
- Up step:
  - sec ones increment; carry 9->0 into tens.
  - tens carry 5->0 into minutes.
  - minutes increment digit-wise with 9->0 carry.
- Terminal values: down = all zero; up = all-9 minutes : 59.
- The step that produces the terminal value:
  - value updates; state -> DONE, done=1, expire=1 (one cycle), running=0.
  - all on the same edge.
- Entering RUN from IDLE or PAUSE while already at the terminal value:
  - goes to DONE on that edge, with expire=1 and no step applied.
- DONE:
  - value frozen; run ignored.
  - exits only via load or reset.
- No wrap-around past the terminal value under any input.
- running=1 exactly while state==RUN.
- Reset mid-count: all state cleared immediately. Counting resumes only after load then run.

Test Plan:
- TICKS_PER_SEC=4, MIN_DIGITS=2:
  - load 01:00, mode=0, run=1 -> first sec_tick 4 cycles after RUN entry, value 00:59.
  - then 00:58 four cycles later.
  - borrow 00:59 verified at the 01:00 boundary.
- Load 00:02 down, run=1:
  - 00:01 after 4 cycles, 00:00 after 8.
  - on that edge done=1 and expire=1 for exactly one cycle.
  - holding run=1 for 20 more cycles -> value stays 00:00, no further sec_tick.
- Load 99:58 mode=1, run=1 -> 99:59 after 4 cycles, then DONE with expire. No wrap to 00:00.
- Pause/resume:
  - load 00:10 down; run=1 for 6 cycles -> 00:09 and prescaler=2.
  - run=0 for 50 cycles -> value and prescaler unchanged, running=0.
  - run=1 -> 00:08 after exactly 2 more cycles.
- Clamp and priority:
  - load min=0xA3, sec=0x6B -> 93:59.
  - load asserted together with run=1 in RUN -> state IDLE, prescaler=0, no step that cycle.
- Reset and zero start:
  - resetn low mid-RUN -> all outputs 0 asynchronously.
  - after release: load 00:00 down, run=1 -> DONE with expire on the first RUN edge, sec_tick never asserted.
